// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer.
//   state_t      : sequencer states IDLE -> CLEAR -> FEED -> DONE
//   feed_len()   : number of FEED cycles for an N x N array (3N-2)
//   cnt_width()  : width of the feed counter for an N x N array
//   lane_hit()   : skew helper, true when lane 'lane' reads element 'k' at 'cnt'
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DONE
    } state_t;

    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(3 * n - 2);
    endfunction

    // Values for the default 4 x 4 array.
    localparam int FEED_LEN = feed_len(4);
    localparam int CNT_W    = cnt_width(4);

    // Lane 'lane' is delayed by 'lane' cycles, so at feed step 'cnt' it
    // presents element cnt-lane. Evaluated on int so cnt-lane never wraps;
    // callers only pass k in 0..N-1, which bounds the valid window.
    function automatic logic lane_hit(input int cnt, input int lane, input int k);
        return (cnt - lane) == k;
    endfunction

endpackage

// File: rtl/operand_bank.sv
// N x N operand register file with a skewed read port.
//   clk_i, rst_ni : clock, asynchronous active-low reset (zeroes the bank)
//   wr_en_i       : write wr_data_i into entry wr_idx_i this cycle
//   wr_idx_i      : entry (row of A, or column of B) to write
//   wr_data_i     : N elements, element k in bits [k*DATA_WIDTH +: DATA_WIDTH]
//   rd_en_i       : enable the skewed read (outputs 0 when low)
//   cnt_i         : feed step; lane l outputs entry l, element cnt_i-l
//   rd_data_o     : N lanes, lane l in bits [l*DATA_WIDTH +: DATA_WIDTH]
module operand_bank
    import systolic_pkg::*;
#(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [$clog2(N)-1:0]    wr_idx_i,
    input  logic [N*DATA_WIDTH-1:0] wr_data_i,
    input  logic                    rd_en_i,
    input  logic [CNT_W-1:0]        cnt_i,
    output logic [N*DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] r_mem [N][N];

    // NOTE: the storage is reset because a reset must leave the banks
    // zeroed, so this array cannot map onto a reset-less RAM macro.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    r_mem[r][c] <= '0;
        end else if (wr_en_i) begin
            for (int c = 0; c < N; c++)
                r_mem[wr_idx_i][c] <= wr_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // NOTE: the output is defaulted before the loops so every path assigns
    // it and no latch is inferred.
    always_comb begin
        rd_data_o = '0;
        if (rd_en_i) begin
            for (int l = 0; l < N; l++)
                for (int k = 0; k < N; k++)
                    if (lane_hit(int'(cnt_i), l, k))
                        rd_data_o[l*DATA_WIDTH +: DATA_WIDTH] = r_mem[l][k];
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_en_i       : write one operand vector (accepted only in IDLE)
//   wr_sel_i      : 0 = A row, 1 = B column
//   wr_idx_i      : row index for A, column index for B
//   wr_data_i     : N elements, element k in bits [k*DATA_WIDTH +: DATA_WIDTH]
//   start_i       : begin a multiply (sampled only in IDLE)
//   carry_i       : OR of all PE carry outputs
//   left_o, up_o  : skewed operand lanes into the array's left / top edges
//   pe_rst_no     : registered active-low accumulator clear
//   busy_o        : high in CLEAR and FEED
//   done_o        : one-cycle pulse when results are valid
//   ovf_o         : sticky overflow for the current multiply
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic                    wr_sel_i,
    input  logic [$clog2(N)-1:0]    wr_idx_i,
    input  logic [N*DATA_WIDTH-1:0] wr_data_i,
    input  logic                    start_i,
    input  logic                    carry_i,
    output logic [N*DATA_WIDTH-1:0] left_o,
    output logic [N*DATA_WIDTH-1:0] up_o,
    output logic                    pe_rst_no,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    ovf_o
);

    localparam int                L_CNT_W  = cnt_width(N);
    localparam logic [L_CNT_W-1:0] CNT_LAST = L_CNT_W'(feed_len(N) - 1);

    state_t               r_state;
    logic [L_CNT_W-1:0]   r_cnt;
    logic                 r_pe_rst_n;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ovf;

    logic                 w_idle;
    logic                 w_feed;
    logic                 w_wr_a;
    logic                 w_wr_b;

    assign w_idle = (r_state == ST_IDLE);
    assign w_feed = (r_state == ST_FEED);
    // Banks only change in IDLE, so operands are frozen for a whole multiply.
    assign w_wr_a = wr_en_i && w_idle && !wr_sel_i;
    assign w_wr_b = wr_en_i && w_idle &&  wr_sel_i;

    // Outputs are registered alongside the state so they change on the same
    // edge as the state they describe.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pe_rst_n <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_pe_rst_n <= 1'b1;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state    <= ST_CLEAR;
                        r_ovf      <= 1'b0;
                        r_pe_rst_n <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_state <= ST_FEED;
                    r_cnt   <= '0;
                end
                ST_FEED: begin
                    if (carry_i)
                        r_ovf <= 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + L_CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (carry_i)
                        r_ovf <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    operand_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH), .CNT_W(L_CNT_W)) u_bank_a (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (w_wr_a),
        .wr_idx_i  (wr_idx_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (w_feed),
        .cnt_i     (r_cnt),
        .rd_data_o (left_o)
    );

    // B is stored by column, so entry j element k is B[k][j] and the same
    // [lane][cnt-lane] read yields B[cnt-j][j] on lane j.
    operand_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH), .CNT_W(L_CNT_W)) u_bank_b (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (w_wr_b),
        .wr_idx_i  (wr_idx_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (w_feed),
        .cnt_i     (r_cnt),
        .rd_data_o (up_o)
    );

    assign pe_rst_no = r_pe_rst_n;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign ovf_o     = r_ovf;

endmodule
